// File: rtl/decode_operand_stage.sv
// Decode and register-read stage for the KGP-RISC datapath.
// Decodes a 32-bit instruction, reads rs/rt from an internal register file
// with same-cycle write-back bypass, interlocks on pending destinations via
// a scoreboard, and presents the operand bundle from one registered slot
// that holds under backpressure.
module decode_operand_stage #(
  parameter int NREGS = 32,
  parameter bit SB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rsData,
  output logic [31:0] rtData,
  output logic [4:0]  shamt,
  output logic [21:0] imm,
  output logic [2:0]  opcode,
  output logic [3:0]  fcode,
  output logic [4:0]  rs_addr
);

  logic [31:0]      regs_r [NREGS];
  logic [NREGS-1:0] pending_r;
  logic [NREGS-1:0] pending_nxt_s;

  logic [2:0]  opcode_s;
  logic [3:0]  fcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  shamt_s;
  logic [21:0] imm_s;
  logic        rtype_s;
  logic        writes_s;
  logic        rs_wb_hit_s;
  logic        rt_wb_hit_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic        hz_s;
  logic        accept_s;

  // Field extraction, source/destination classification and bypassed reads.
  always_comb begin
    opcode_s = in_instr[31:29];
    fcode_s  = in_instr[28:25];
    rs_s     = in_instr[24:20];
    rt_s     = in_instr[19:15];
    shamt_s  = in_instr[14:10];
    imm_s    = in_instr[21:0];
    rtype_s  = (opcode_s == 3'b000);
    case (opcode_s)
      3'b000, 3'b001, 3'b010: writes_s = 1'b1;
      default:                writes_s = 1'b0;
    endcase
    // A write-back to r0 is discarded, so it must never be forwarded either.
    rs_wb_hit_s = wb_en && (wb_addr == rs_s) && (rs_s != 5'd0);
    rt_wb_hit_s = wb_en && (wb_addr == rt_s) && (rt_s != 5'd0);
    if (rs_wb_hit_s) begin
      rs_val_s = wb_data;
    end else begin
      rs_val_s = regs_r[rs_s];
    end
    if (rt_wb_hit_s) begin
      rt_val_s = wb_data;
    end else begin
      rt_val_s = regs_r[rt_s];
    end
  end

  // Hazard detection and handshake; a write-back arriving this cycle resolves its own hazard.
  always_comb begin
    hz_s = (pending_r[rs_s] && !(wb_en && (wb_addr == rs_s))) ||
           (rtype_s && pending_r[rt_s] && !(wb_en && (wb_addr == rt_s)));
    in_ready = !hz_s && (!out_valid || out_ready);
    accept_s = in_valid && in_ready;
  end

  // Next scoreboard state: clear on write-back, then set on accept so set wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (wb_en) begin
      pending_nxt_s[wb_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (accept_s && writes_s) begin
      pending_nxt_s[rs_s] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
    if (SB_EN == 1'b0) begin
      pending_nxt_s = {NREGS{1'b0}};
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Output slot: load on accept, drain when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rsData    <= 32'd0;
      rtData    <= 32'd0;
      shamt     <= 5'd0;
      imm       <= 22'd0;
      opcode    <= 3'd0;
      fcode     <= 4'd0;
      rs_addr   <= 5'd0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      rsData    <= rs_val_s;
      rtData    <= rt_val_s;
      shamt     <= shamt_s;
      imm       <= imm_s;
      opcode    <= opcode_s;
      fcode     <= fcode_s;
      rs_addr   <= rs_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Self-checking bench for decode_operand_stage: directed scenarios followed
// by a randomized phase, all compared against a behavioural model.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [4:0]  shamt;
  logic [21:0] imm;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic [4:0]  rs_addr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic        e_valid;
  logic [31:0] e_rs, e_rt;
  logic [4:0]  e_sh, e_rsa;
  logic [21:0] e_imm;
  logic [2:0]  e_op;
  logic [3:0]  e_fc;

  always #5 clk = ~clk;

  decode_operand_stage #(.NREGS(32), .SB_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rsData(rsData), .rtData(rtData), .shamt(shamt), .imm(imm),
    .opcode(opcode), .fcode(fcode), .rs_addr(rs_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] fc,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] sh);
    return {op, fc, rs, rt, sh, 10'd0};
  endfunction

  function automatic logic [31:0] mki(input logic [2:0] op, input logic [3:0] fc,
                                      input logic [4:0] rs, input logic [19:0] lo);
    return {op, fc, rs, lo};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    out_ready = ordy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    e_valid = 1'b0; e_rs = 32'd0; e_rt = 32'd0; e_sh = 5'd0;
    e_imm = 22'd0; e_op = 3'd0; e_fc = 4'd0; e_rsa = 5'd0;
  endtask

  // One clock: check readiness against the model, advance, check the bundle.
  task automatic step();
    int  op, rsi, rti;
    bit  hz, rdy, acc, wr;
    logic [31:0] rv, tv;
    #2;
    op  = int'(in_instr[31:29]);
    rsi = int'(in_instr[24:20]);
    rti = int'(in_instr[19:15]);
    hz  = (m_busy[rsi] && !(wb_en && int'(wb_addr) == rsi)) ||
          (op == 0 && m_busy[rti] && !(wb_en && int'(wb_addr) == rti));
    rdy = !hz && (!e_valid || out_ready);
    if (in_valid) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = in_valid && rdy;
    wr  = (op <= 2);
    rv  = (wb_en && rsi != 0 && int'(wb_addr) == rsi) ? wb_data : m_regs[rsi];
    tv  = (wb_en && rti != 0 && int'(wb_addr) == rti) ? wb_data : m_regs[rti];
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (acc) begin
        e_valid = 1'b1; e_rs = rv; e_rt = tv;
        e_sh = in_instr[14:10]; e_imm = in_instr[21:0];
        e_op = in_instr[31:29]; e_fc = in_instr[28:25]; e_rsa = in_instr[24:20];
      end else if (e_valid && out_ready) begin
        e_valid = 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (acc && wr && rsi != 0) m_busy[rsi] = 1'b1;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("rsData", rsData, e_rs);
    chk("rtData", rtData, e_rt);
    chk("shamt", {27'd0, shamt}, {27'd0, e_sh});
    chk("imm", {10'd0, imm}, {10'd0, e_imm});
    chk("opcode", {29'd0, opcode}, {29'd0, e_op});
    chk("fcode", {28'd0, fcode}, {28'd0, e_fc});
    chk("rs_addr", {27'd0, rs_addr}, {27'd0, e_rsa});
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_rsData", rsData, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Load r5=5, r6=6, r7=0x1234
    drive(1'b0, 32'd0, 1'b1, 5'd5, 32'd5, 1'b1); step();
    drive(1'b0, 32'd0, 1'b1, 5'd6, 32'd6, 1'b1); step();
    drive(1'b0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b1); step();

    // R-type rs=5 rt=6 shamt=4
    drive(1'b1, mk(3'b000, 4'b0000, 5'd5, 5'd6, 5'd4), 1'b0, 5'd0, 32'd0, 1'b1); step();
    chk("rtype_valid", {31'd0, out_valid}, 32'd1);
    chk("rtype_rs", rsData, 32'd5);
    chk("rtype_rt", rtData, 32'd6);
    chk("rtype_shamt", {27'd0, shamt}, 32'd4);
    chk("rtype_fcode", {28'd0, fcode}, 32'd0);
    // R-type marked r5 pending; release it
    drive(1'b0, 32'd0, 1'b1, 5'd5, 32'd5, 1'b1); step();

    // I-type writing r5 with simultaneous write-back r5=9
    drive(1'b1, mki(3'b001, 4'b0000, 5'd5, 20'd4), 1'b1, 5'd5, 32'd9, 1'b1); step();
    chk("bypass_rs", rsData, 32'd9);
    chk("imm_low", {12'd0, imm[19:0]}, 32'd4);

    // Reader of pending r5 stalls until the write-back shows up
    drive(1'b1, mk(3'b000, 4'b0001, 5'd5, 5'd6, 5'd0), 1'b0, 5'd0, 32'd0, 1'b1);
    #1; chk("stall_rdy0", {31'd0, in_ready}, 32'd0);
    step(); step();
    drive(1'b1, mk(3'b000, 4'b0001, 5'd5, 5'd6, 5'd0), 1'b1, 5'd5, 32'h77, 1'b1);
    #1; chk("resume_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("resume_rs", rsData, 32'h77);
    drive(1'b0, 32'd0, 1'b1, 5'd5, 32'h77, 1'b0); step();

    // Backpressure: held bundle, three stalled cycles, then back-to-back
    drive(1'b1, mk(3'b100, 4'b0010, 5'd6, 5'd6, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_rs", rsData, 32'h77);
    end
    drive(1'b1, mk(3'b100, 4'b0010, 5'd6, 5'd6, 5'd1), 1'b0, 5'd0, 32'd0, 1'b1); step();
    chk("b2b_fc1", {28'd0, fcode}, 32'd2);
    drive(1'b1, mk(3'b101, 4'b0011, 5'd7, 5'd6, 5'd2), 1'b0, 5'd0, 32'd0, 1'b1); step();
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_fc2", {28'd0, fcode}, 32'd3);

    // r0 ignores writes and never becomes pending
    drive(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1); step();
    drive(1'b1, mk(3'b011, 4'b0000, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b1); step();
    chk("r0_read", rsData, 32'd0);
    drive(1'b1, mki(3'b001, 4'b0000, 5'd0, 20'd1), 1'b0, 5'd0, 32'd0, 1'b1); step();
    drive(1'b1, mk(3'b000, 4'b0000, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b1);
    #1; chk("r0_no_stall", {31'd0, in_ready}, 32'd1);
    step();

    // Reset while a bundle is held and r7 is pending
    drive(1'b1, mki(3'b010, 4'b0000, 5'd7, 20'd0), 1'b0, 5'd0, 32'd0, 1'b0); step();
    drive(1'b1, mk(3'b011, 4'b0000, 5'd7, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b0); step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, mk(3'b011, 4'b0000, 5'd7, 5'd0, 5'd0), 1'b0, 5'd0, 32'd0, 1'b1);
    #1; chk("rst_r7_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("rst_r7_val", rsData, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 6, ins, $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
